decode_stage: RTL and testbench
===============================

# decode_stage

Instruction-decode stage of the RISC-V pipeline: accepts a fetched 32-bit instruction, reads the integer register file, builds the sign-extended immediate and emits the operand/control bundle (reg_data1, reg_data2, imm, select_imm, funct3, funct7, ALUOp) through a registered ID/EX boundary. Its outputs drive the ExecuteStage operand and control inputs directly. It owns the 32x32 register file and its write-back port.

## Interface
- XLEN, 32, datapath width
- NREG, 32, architectural registers; x0 hard-wired to zero
- clk  in  1  pipeline clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset (asserted when 0)
- in_valid / in_ready  in / out  1  fetch-side handshake
- instr  in  32  instruction word
- flush  in  1  kill held and incoming instruction (branch taken)
- wb_en  in  1  register write enable; wb_rd  in  5; wb_data  in  XLEN
- out_valid / out_ready  out / in  1  execute-side handshake
- reg_data1, reg_data2, imm  out  XLEN  operands
- select_imm  out  1  1 selects imm as ALU B operand
- funct3  out  3; funct7  out  7; ALUOp  out  2
- rd  out  5; reg_write, mem_read, mem_write, branch, illegal  out  1

## Operation
- Transfer on a side when valid and ready both high on a rising edge.
- in_ready = !out_valid | out_ready (combinational, one-deep skid-free register).
- Opcode decode:
  - R-type 0110011: ALUOp 10, select_imm 0, funct7 = instr[31:25], reg_write 1.
  - OP-IMM 0010011: ALUOp 10, select_imm 1, I-imm, funct7 = instr[31:25] only when funct3 = 101, else 0000000.
  - LOAD 0000011: ALUOp 00, select_imm 1, I-imm, mem_read 1, reg_write 1.
  - STORE 0100011: ALUOp 00, select_imm 1, S-imm, mem_write 1.
  - BRANCH 1100011: ALUOp 01, select_imm 0, B-imm, branch 1.
  - LUI 0110111: reg_data1 forced 0, ALUOp 00, select_imm 1, U-imm.
  - Any other opcode: illegal 1; reg_write, mem_read, mem_write and branch all 0.
- Immediates are sign-extended from instr[31].
- Register file: x0 reads 0; writes to x0 ignored; write on rising edge when wb_en.
- Stall snoop: while out_valid & !out_ready, a write-back whose wb_rd equals the held rs1/rs2 (nonzero) updates the held reg_data1/reg_data2.
- flush: next edge clears out_valid; an instruction offered in the same cycle is consumed (in_ready unaffected) and dropped. Write-back still commits.

## Timing
- Reset: out_valid 0, all other outputs 0, all registers 0.
- Latency: 1 cycle; accepted on edge N, visible with out_valid on edge N+1.
- Outputs are stable while out_valid & !out_ready, except snoop updates.
- Reset mid-operation discards the held instruction immediately (asynchronous).
- Simultaneous accept and output transfer: new bundle replaces old with no bubble.

## Configuration
- DECODE_WB_BYPASS_EN defined: a same-cycle write-back to rs1/rs2 (nonzero) is forwarded into the captured operand.
- Undefined: the captured operand is the pre-write value. The hazard unit must then separate write-back and decode by one cycle.
- The stall snoop is present in both builds.

## Structure
- riscv_pkg: opcode localparams, ALUOp encodings (00 add, 01 sub/compare, 10 funct-decoded), immediate-type enum, XLEN.
- Sub-module regfile: 2 async read ports, 1 write port, async clear.
- decode_stage contains the decoder, immediate generator, bypass/snoop logic and the ID/EX register.

## Test plan
- Reset: hold rst=0 with in_valid=1 → out_valid 0 and all outputs 0; release rst → first instruction appears one cycle after acceptance.
- Write-back then decode: wb x5=10, x6=20; decode add x7,x5,x6 → reg_data1 10, reg_data2 20, ALUOp 10, funct7 0000000, select_imm 0.
- Immediates:
  - addi x1,x0,-5 → imm 0xFFFFFFFB, select_imm 1, reg_data1 0.
  - sub → funct7 0100000.
  - srai → funct7 0100000.
  - slti → funct7 0000000.
- Bypass: wb x5=99 in the same cycle that add x7,x5,x0 is accepted → reg_data1 99 with the macro defined; prior value without it.
- Stall: hold out_ready=0 for 3 cycles → outputs stable and in_ready 0. Write-back of x5=7 during the stall → held reg_data1 becomes 7. Drop the stall → one transfer.
- Flush and illegal:
  - flush while stalled → out_valid 0 next cycle.
  - Instruction 0xFFFFFFFF → illegal 1, reg_write 0, mem_write 0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V decode definitions: opcodes, ALUOp encodings, immediate types and the ID/EX bundle.
`default_nettype none

package riscv_pkg;

  localparam int XLEN   = 32;
  localparam int NREG   = 32;
  localparam int REG_AW = 5;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4
  } imm_type_e;

  typedef struct packed {
    logic [XLEN-1:0]   rd1;
    logic [XLEN-1:0]   rd2;
    logic [XLEN-1:0]   imm;
    logic              select_imm;
    logic [2:0]        funct3;
    logic [6:0]        funct7;
    logic [1:0]        alu_op;
    logic [REG_AW-1:0] rd;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic              branch;
    logic              illegal;
  } id_ex_t;

  function automatic logic [XLEN-1:0] gen_imm(input logic [31:0] ins, input imm_type_e t);
    logic [XLEN-1:0] r;
    case (t)
      IMM_I:   r = {{20{ins[31]}}, ins[31:20]};
      IMM_S:   r = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      IMM_B:   r = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      IMM_U:   r = {ins[31:12], 12'b0};
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/regfile.sv
// Integer register file: two asynchronous read ports, one write port, x0 hard-wired to zero.
`default_nettype none

module regfile
  import riscv_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] raddr1_i,
  input  logic [REG_AW-1:0] raddr2_i,
  output logic [XLEN-1:0]   rdata1_o,
  output logic [XLEN-1:0]   rdata2_o,
  input  logic              we_i,
  input  logic [REG_AW-1:0] waddr_i,
  input  logic [XLEN-1:0]   wdata_i
);

  logic [XLEN-1:0] regs_q [NREG];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else if (we_i && (waddr_i != '0)) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata1_o = (raddr1_i == '0) ? '0 : regs_q[raddr1_i];
  assign rdata2_o = (raddr2_i == '0) ? '0 : regs_q[raddr2_i];

endmodule

`default_nettype wire

// File: rtl/decode_stage.sv
// RISC-V instruction decode stage with register file and registered ID/EX boundary.
// Optional DECODE_WB_BYPASS_EN forwards a same-cycle write-back into the captured operands.
`default_nettype none

module decode_stage
  import riscv_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       instr,
  input  logic              flush,
  input  logic              wb_en,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [XLEN-1:0]   wb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   reg_data1,
  output logic [XLEN-1:0]   reg_data2,
  output logic [XLEN-1:0]   imm,
  output logic              select_imm,
  output logic [2:0]        funct3,
  output logic [6:0]        funct7,
  output logic [1:0]        ALUOp,
  output logic [REG_AW-1:0] rd,
  output logic              reg_write,
  output logic              mem_read,
  output logic              mem_write,
  output logic              branch,
  output logic              illegal
);

  logic [6:0]        opcode;
  logic [REG_AW-1:0] rs1_a, rs2_a, rs1_d;
  logic [XLEN-1:0]   rf_rd1, rf_rd2, op1, op2;
  imm_type_e         imm_type;
  id_ex_t            bundle_d, bundle_q;
  logic              valid_q;
  logic [REG_AW-1:0] rs1_q, rs2_q;
  logic              accept, stalled, snoop1, snoop2;

  assign opcode = instr[6:0];
  assign rs1_a  = instr[19:15];
  assign rs2_a  = instr[24:20];

  regfile u_regfile (
    .clk      (clk),
    .rst_n    (rst),
    .raddr1_i (rs1_a),
    .raddr2_i (rs2_a),
    .rdata1_o (rf_rd1),
    .rdata2_o (rf_rd2),
    .we_i     (wb_en),
    .waddr_i  (wb_rd),
    .wdata_i  (wb_data)
  );

`ifdef DECODE_WB_BYPASS_EN
  assign op1 = (wb_en && (wb_rd == rs1_a) && (rs1_a != '0)) ? wb_data : rf_rd1;
  assign op2 = (wb_en && (wb_rd == rs2_a) && (rs2_a != '0)) ? wb_data : rf_rd2;
`else
  assign op1 = rf_rd1;
  assign op2 = rf_rd2;
`endif

  // OP-IMM and LUI also write rd; only funct3=101 (shift-right) carries a meaningful funct7.
  always_comb begin
    bundle_d        = '0;
    imm_type        = IMM_NONE;
    rs1_d           = rs1_a;
    bundle_d.rd1    = op1;
    bundle_d.rd2    = op2;
    bundle_d.funct3 = instr[14:12];
    bundle_d.rd     = instr[11:7];
    case (opcode)
      OP_R: begin
        bundle_d.alu_op    = ALU_FUNCT;
        bundle_d.funct7    = instr[31:25];
        bundle_d.reg_write = 1'b1;
      end
      OP_IMM: begin
        bundle_d.alu_op     = ALU_FUNCT;
        bundle_d.select_imm = 1'b1;
        imm_type            = IMM_I;
        bundle_d.funct7     = (instr[14:12] == 3'b101) ? instr[31:25] : 7'b0;
        bundle_d.reg_write  = 1'b1;
      end
      OP_LOAD: begin
        bundle_d.alu_op     = ALU_ADD;
        bundle_d.select_imm = 1'b1;
        imm_type            = IMM_I;
        bundle_d.mem_read   = 1'b1;
        bundle_d.reg_write  = 1'b1;
      end
      OP_STORE: begin
        bundle_d.alu_op     = ALU_ADD;
        bundle_d.select_imm = 1'b1;
        imm_type            = IMM_S;
        bundle_d.mem_write  = 1'b1;
      end
      OP_BRANCH: begin
        bundle_d.alu_op = ALU_SUB;
        imm_type        = IMM_B;
        bundle_d.branch = 1'b1;
      end
      OP_LUI: begin
        bundle_d.rd1        = '0;
        rs1_d               = '0;
        bundle_d.alu_op     = ALU_ADD;
        bundle_d.select_imm = 1'b1;
        imm_type            = IMM_U;
        bundle_d.reg_write  = 1'b1;
      end
      default: bundle_d.illegal = 1'b1;
    endcase
    bundle_d.imm = gen_imm(instr, imm_type);
  end

  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign stalled  = valid_q && !out_ready;
  assign snoop1   = stalled && wb_en && (wb_rd == rs1_q) && (rs1_q != '0);
  assign snoop2   = stalled && wb_en && (wb_rd == rs2_q) && (rs2_q != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q  <= 1'b0;
      bundle_q <= '0;
      rs1_q    <= '0;
      rs2_q    <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (accept) begin
      valid_q  <= 1'b1;
      bundle_q <= bundle_d;
      rs1_q    <= rs1_d;
      rs2_q    <= rs2_a;
    end else if (out_ready) begin
      valid_q <= 1'b0;
    end else begin
      if (snoop1) bundle_q.rd1 <= wb_data;
      if (snoop2) bundle_q.rd2 <= wb_data;
    end
  end

  assign out_valid  = valid_q;
  assign reg_data1  = bundle_q.rd1;
  assign reg_data2  = bundle_q.rd2;
  assign imm        = bundle_q.imm;
  assign select_imm = bundle_q.select_imm;
  assign funct3     = bundle_q.funct3;
  assign funct7     = bundle_q.funct7;
  assign ALUOp      = bundle_q.alu_op;
  assign rd         = bundle_q.rd;
  assign reg_write  = bundle_q.reg_write;
  assign mem_read   = bundle_q.mem_read;
  assign mem_write  = bundle_q.mem_write;
  assign branch     = bundle_q.branch;
  assign illegal    = bundle_q.illegal;

endmodule

`default_nettype wire

// File: tb/tb_decode_stage.sv
// Scoreboard testbench for decode_stage: driver pushes expected bundles, monitor pops on each output transfer.
`timescale 1ns/1ps
`default_nettype none

module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [31:0] instr;
  logic        flush;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        out_valid, out_ready;
  logic [31:0] reg_data1, reg_data2, imm;
  logic        select_imm;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [1:0]  ALUOp;
  logic [4:0]  rd;
  logic        reg_write, mem_read, mem_write, branch, illegal;

  always #5 clk = ~clk;

  decode_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
    .flush(flush), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .reg_data1(reg_data1), .reg_data2(reg_data2), .imm(imm), .select_imm(select_imm),
    .funct3(funct3), .funct7(funct7), .ALUOp(ALUOp), .rd(rd),
    .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
    .branch(branch), .illegal(illegal)
  );

  typedef struct packed {
    logic [31:0] rd1, rd2, imm;
    logic        sel;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [1:0]  alu;
    logic [4:0]  rd;
    logic [4:0]  ctl;  // {reg_write, mem_read, mem_write, branch, illegal}
  } exp_t;

`ifdef DECODE_WB_BYPASS_EN
  localparam logic [31:0] BYP_RD1 = 32'd99;
`else
  localparam logic [31:0] BYP_RD1 = 32'd10;
`endif

  exp_t exp_q[$];
  int   errors = 0, checks = 0, transfers = 0, sent = 0;
  exp_t mon_got, mon_exp;

  function automatic exp_t mk(input logic [31:0] rd1, input logic [31:0] rd2, input logic [31:0] im,
                              input logic sel, input logic [2:0] f3, input logic [6:0] f7,
                              input logic [1:0] alu, input logic [4:0] rdn, input logic [4:0] ctl);
    mk = {rd1, rd2, im, sel, f3, f7, alu, rdn, ctl};
  endfunction

  function automatic exp_t cur();
    cur = {reg_data1, reg_data2, imm, select_imm, funct3, funct7, ALUOp, rd,
           reg_write, mem_read, mem_write, branch, illegal};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic chk_b(input string name, input exp_t got, input exp_t want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  // Monitor: a transfer is committed at the next rising edge when both are high here.
  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      transfers++;
      if (exp_q.size() == 0) begin
        chk("unexpected_transfer", 32'd1, 32'd0);
      end else begin
        mon_exp = exp_q.pop_front();
        mon_got = cur();
        chk_b($sformatf("bundle#%0d", transfers), mon_got, mon_exp);
      end
    end
  end

  task automatic send(input logic [31:0] ins, input exp_t e);
    int n = 0;
    instr    = ins;
    in_valid = 1'b1;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) chk("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    exp_q.push_back(e);
    sent++;
    #1;
    in_valid = 1'b0;
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b1; instr = 32'h006283B3; flush = 1'b0;
    wb_en = 1'b0; wb_rd = '0; wb_data = '0; out_ready = 1'b1;

    // Reset held with a pending instruction
    cyc(); cyc();
    chk("rst_out_valid", out_valid, 0);
    chk_b("rst_outputs_zero", cur(), '0);

    rst = 1'b1;
    send(32'h006283B3, mk(0, 0, 0, 0, 3'd0, 7'h00, 2'b10, 5'd7, 5'b10000));
    chk("first_latency_valid", out_valid, 1);

    wb_en = 1'b1; wb_rd = 5'd5; wb_data = 32'd10;
    cyc();
    wb_rd = 5'd6; wb_data = 32'd20;
    cyc();
    wb_en = 1'b0;

    // Back-to-back decode of every format
    send(32'h006283B3, mk(10, 20, 0, 0, 3'd0, 7'h00, 2'b10, 5'd7, 5'b10000));           // add x7,x5,x6
    send(32'hFFB00093, mk(0, 0, 32'hFFFFFFFB, 1, 3'd0, 7'h00, 2'b10, 5'd1, 5'b10000)); // addi x1,x0,-5
    send(32'h40530433, mk(20, 10, 0, 0, 3'd0, 7'h20, 2'b10, 5'd8, 5'b10000));          // sub x8,x6,x5
    send(32'h40335493, mk(20, 0, 32'h403, 1, 3'd5, 7'h20, 2'b10, 5'd9, 5'b10000));     // srai x9,x6,3
    send(32'hFFF2A513, mk(10, 0, 32'hFFFFFFFF, 1, 3'd2, 7'h00, 2'b10, 5'd10, 5'b10000)); // slti x10,x5,-1
    send(32'h0082A583, mk(10, 0, 32'd8, 1, 3'd2, 7'h00, 2'b00, 5'd11, 5'b11000));      // lw x11,8(x5)
    send(32'hFE62AE23, mk(10, 20, 32'hFFFFFFFC, 1, 3'd2, 7'h00, 2'b00, 5'd28, 5'b00100)); // sw x6,-4(x5)
    send(32'h00628863, mk(10, 20, 32'd16, 0, 3'd0, 7'h00, 2'b01, 5'd16, 5'b00010));    // beq x5,x6,+16
    send(32'h00028637, mk(0, 0, 32'h00028000, 1, 3'd0, 7'h00, 2'b00, 5'd12, 5'b10000)); // lui x12,0x28
    send(32'hFFFFFFFF, mk(0, 0, 0, 0, 3'd7, 7'h00, 2'b00, 5'd31, 5'b00001));           // illegal

    // Write-back in the same cycle as decode
    wb_en = 1'b1; wb_rd = 5'd5; wb_data = 32'd99;
    send(32'h000283B3, mk(BYP_RD1, 0, 0, 0, 3'd0, 7'h00, 2'b10, 5'd7, 5'b10000));      // add x7,x5,x0
    wb_en = 1'b0;
    cyc();

    // Three-cycle stall with a snooped write-back
    out_ready = 1'b0;
    send(32'h006283B3, mk(7, 20, 0, 0, 3'd0, 7'h00, 2'b10, 5'd7, 5'b10000));
    chk("stall0_valid", out_valid, 1);
    chk("stall0_in_ready", in_ready, 0);
    chk("stall0_rd1", reg_data1, 32'd99);
    wb_en = 1'b1; wb_rd = 5'd5; wb_data = 32'd7;
    cyc();
    wb_en = 1'b0;
    chk("stall1_in_ready", in_ready, 0);
    chk("stall1_snoop_rd1", reg_data1, 32'd7);
    cyc();
    chk("stall2_valid", out_valid, 1);
    chk("stall2_rd2", reg_data2, 32'd20);
    chk("stall2_alu", ALUOp, 2'b10);
    out_ready = 1'b1;
    cyc();
    chk("stall_single_transfer", out_valid, 0);

    // Flush while stalled
    out_ready = 1'b0;
    send(32'h40530433, mk(20, 7, 0, 0, 3'd0, 7'h20, 2'b10, 5'd8, 5'b10000));
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    void'(exp_q.pop_back());
    sent--;
    chk("flush_stalled_valid", out_valid, 0);
    out_ready = 1'b1;

    // Flush with an incoming instruction and a write-back
    flush = 1'b1; in_valid = 1'b1; instr = 32'h006283B3;
    wb_en = 1'b1; wb_rd = 5'd13; wb_data = 32'd55;
    chk("flush_in_ready", in_ready, 1);
    cyc();
    flush = 1'b0; in_valid = 1'b0; wb_en = 1'b0;
    chk("flush_drop_valid", out_valid, 0);
    send(32'h00068733, mk(55, 0, 0, 0, 3'd0, 7'h00, 2'b10, 5'd14, 5'b10000));         // add x14,x13,x0
    cyc();

    // Asynchronous reset while holding an instruction
    out_ready = 1'b0;
    send(32'h006283B3, mk(7, 20, 0, 0, 3'd0, 7'h00, 2'b10, 5'd7, 5'b10000));
    #2 rst = 1'b0;
    #1;
    chk("async_rst_valid", out_valid, 0);
    chk("async_rst_rd1", reg_data1, 0);
    void'(exp_q.pop_back());
    sent--;
    cyc();
    rst = 1'b1; out_ready = 1'b1;
    send(32'h006283B3, mk(0, 0, 0, 0, 3'd0, 7'h00, 2'b10, 5'd7, 5'b10000));

    repeat (3) cyc();
    chk("queue_empty", exp_q.size(), 0);
    chk("transfer_count", transfers, sent);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
